// File: rtl/seg_scan_ctrl.sv
// Scan controller that time-shares one dec7seg decoder across DIGITS common-anode digits,
// with double-buffered digit values committed only at frame boundaries.
module seg_scan_ctrl #(
   parameter int DIGITS       = 4,
   parameter int BLANK_CYCLES = 2,
   parameter int SHOW_CYCLES  = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic [$clog2(DIGITS)-1:0] wr_addr,
   input  logic [3:0]                wr_data,
   input  logic                      commit,
   input  logic [DIGITS-1:0]         dig_en,
   output logic [3:0]                x,
   output logic [DIGITS-1:0]         an,
   output logic [$clog2(DIGITS)-1:0] digit_idx,
   output logic                      frame_done,
   output logic                      commit_pend
);

   localparam int MAXC = (BLANK_CYCLES > SHOW_CYCLES) ? BLANK_CYCLES : SHOW_CYCLES;
   localparam int CW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);
   localparam int IW   = $clog2(DIGITS);

   typedef enum logic {BLANK, SHOW} state_t;

   state_t            state;
   state_t            nxt_state;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     nxt_cnt;
   logic [IW-1:0]     nxt_idx;
   logic              en_lat;
   logic              nxt_en;
   logic [3:0]        shadow     [DIGITS];
   logic [3:0]        active     [DIGITS];
   logic [3:0]        shadow_nxt [DIGITS];
   logic [3:0]        active_nxt [DIGITS];
   logic              do_copy;
   logic [DIGITS-1:0] nxt_an;
   logic [3:0]        nxt_x;
   logic              nxt_fd;

   // Shadow view including this cycle's write, so a write coinciding with the boundary copy is kept.
   always_comb begin
      shadow_nxt = shadow;
      if (wr_en && (int'(wr_addr) < DIGITS)) begin
         shadow_nxt[wr_addr] = wr_data;
      end
   end

   // frame_done is high exactly on the boundary cycle, so it doubles as the copy window.
   assign do_copy = frame_done && (commit_pend || commit);

   always_comb begin
      active_nxt = active;
      if (do_copy) begin
         active_nxt = shadow_nxt;
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt + CW'(1);
      nxt_idx   = digit_idx;
      nxt_en    = en_lat;
      case (state)
         BLANK: begin
            if (cnt == CW'(BLANK_CYCLES - 1)) begin
               nxt_state = SHOW;
               nxt_cnt   = '0;
               nxt_en    = dig_en[digit_idx];
            end
         end
         SHOW: begin
            if (cnt == CW'(SHOW_CYCLES - 1)) begin
               nxt_state = BLANK;
               nxt_cnt   = '0;
               nxt_idx   = (digit_idx == IW'(DIGITS - 1)) ? '0 : digit_idx + IW'(1);
            end
         end
         default: begin
            nxt_state = BLANK;
            nxt_cnt   = '0;
         end
      endcase
   end

   // Outputs are derived from the next state so the registered values line up with the state they describe.
   always_comb begin
      nxt_an = '1;
      if (nxt_state == SHOW) begin
         nxt_an[nxt_idx] = ~nxt_en;
      end
      nxt_x = x;
      if ((state == SHOW) && (nxt_state == BLANK)) begin
         nxt_x = active_nxt[nxt_idx];
      end
      nxt_fd = (nxt_state == SHOW) && (nxt_cnt == CW'(SHOW_CYCLES - 1)) &&
               (nxt_idx == IW'(DIGITS - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BLANK;
         cnt         <= '0;
         digit_idx   <= '0;
         en_lat      <= 1'b0;
         an          <= '1;
         x           <= '0;
         frame_done  <= 1'b0;
         commit_pend <= 1'b0;
         shadow      <= '{default: '0};
         active      <= '{default: '0};
      end else begin
         state      <= nxt_state;
         cnt        <= nxt_cnt;
         digit_idx  <= nxt_idx;
         en_lat     <= nxt_en;
         an         <= nxt_an;
         x          <= nxt_x;
         frame_done <= nxt_fd;
         shadow     <= shadow_nxt;
         active     <= active_nxt;
         if (frame_done) begin
            commit_pend <= 1'b0;
         end else if (commit) begin
            commit_pend <= 1'b1;
         end
      end
   end

endmodule
